// File: rtl/playfield_rd_if.sv
// Bundle of window timing, requester handshake and playfield BRAM read signals.
interface playfield_rd_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  localparam int unsigned AW = 10;
  localparam int unsigned VW = 17;
  localparam int unsigned RW = 1024;

  logic [VW-1:0]         h_count;
  logic [VW-1:0]         v_count;
  logic [NUM_REQ-1:0]    req;
  logic [AW*NUM_REQ-1:0] req_addr;
  logic [AW-1:0]         r_addr_lsb;
  logic [AW-1:0]         r_addr_msb;
  logic [0:RW-1]         r_data_lsb;
  logic [0:RW-1]         r_data_msb;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rd_valid;
  logic [0:RW-1]         rd_data_lsb;
  logic [0:RW-1]         rd_data_msb;
  logic                  busy;
  logic                  window_miss;

  // Arbiter side.
  modport slave (
    input  h_count, v_count, req, req_addr, r_data_lsb, r_data_msb,
    output r_addr_lsb, r_addr_msb, gnt, rd_valid, rd_data_lsb, rd_data_msb,
           busy, window_miss
  );

  // Requester / BRAM / timing side.
  modport master (
    output h_count, v_count, req, req_addr, r_data_lsb, r_data_msb,
    input  r_addr_lsb, r_addr_msb, gnt, rd_valid, rd_data_lsb, rd_data_msb,
           busy, window_miss
  );
endinterface

// File: rtl/playfield_rd_arbiter.sv
// Round-robin arbiter sharing the dual-plane playfield BRAM read port among
// NUM_REQ requesters; grants are only issued inside a vertical service window.
module playfield_rd_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned WIN_VSTART = 1,
  parameter int unsigned WIN_VEND   = 30
) (
  input logic           clk_65M,
  input logic           clear,
  playfield_rd_if.slave bus
);
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = 3;
  localparam int unsigned AW = 10;
  localparam int unsigned VW = 17;
  localparam int unsigned RW = 1024;

  localparam logic [VW-1:0] V_START  = VW'(WIN_VSTART);
  localparam logic [VW-1:0] V_END    = VW'(WIN_VEND);
  localparam logic [VW-1:0] V_MISS   = VW'(WIN_VEND + 1);
  localparam logic [CW-1:0] LAT      = CW'(RD_LAT);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

  state_t             state, state_d;
  logic [IW-1:0]      last, last_d;
  logic [IW-1:0]      cur, cur_d;
  logic [IW-1:0]      pick;
  logic               found;
  logic [CW-1:0]      cnt, cnt_d;
  logic [AW-1:0]      r_addr, r_addr_d;
  logic [NUM_REQ-1:0] gnt, gnt_d;
  logic [NUM_REQ-1:0] rd_valid, rd_valid_d;
  logic               busy, busy_d;
  logic               capture_en;
  logic [0:RW-1]      data_lsb, data_msb;
  logic               win_open;
  logic               miss_set, miss_clr, window_miss;

  assign win_open = (bus.v_count >= V_START) && (bus.v_count <= V_END);

  // Round-robin pick: first requester after the last one served, with wrap.
  always_comb begin
    pick  = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!found && bus.req[(32'(last) + k) % NUM_REQ]) begin
        pick  = IW'((32'(last) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    cur_d      = cur;
    last_d     = last;
    r_addr_d   = r_addr;
    gnt_d      = gnt;
    rd_valid_d = '0;
    capture_en = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_open && found) begin
          r_addr_d = bus.req_addr[32'(pick)*AW +: AW];
          gnt_d    = NUM_REQ'(1) << pick;
          cur_d    = pick;
          cnt_d    = CW'(1);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt + CW'(1);
        if (cnt == LAT) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        capture_en = 1'b1;
        rd_valid_d = NUM_REQ'(1) << cur;
        gnt_d      = '0;
        last_d     = cur;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and control registers.
  always_ff @(posedge clk_65M or posedge clear) begin
    if (clear) begin
      state    <= IDLE;
      cnt      <= '0;
      cur      <= '0;
      last     <= LAST_RST;
      r_addr   <= '0;
      gnt      <= '0;
      rd_valid <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      cur      <= cur_d;
      last     <= last_d;
      r_addr   <= r_addr_d;
      gnt      <= gnt_d;
      rd_valid <= rd_valid_d;
      busy     <= busy_d;
    end
  end

  // Row capture; held until the next completed read.
  always_ff @(posedge clk_65M or posedge clear) begin
    if (clear) begin
      data_lsb <= '0;
      data_msb <= '0;
    end else if (capture_en) begin
      data_lsb <= bus.r_data_lsb;
      data_msb <= bus.r_data_msb;
    end
  end

  assign miss_set = (bus.v_count == V_MISS) && (bus.h_count == '0) && (|(bus.req & ~gnt));
  assign miss_clr = (bus.v_count == '0) && (bus.h_count == '0);

  // Sticky per-frame flag for requests left unserved when the window closed.
  always_ff @(posedge clk_65M or posedge clear) begin
    if (clear) begin
      window_miss <= 1'b0;
    end else if (miss_set) begin
      window_miss <= 1'b1;
    end else if (miss_clr) begin
      window_miss <= 1'b0;
    end
  end

  assign bus.r_addr_lsb  = r_addr;
  assign bus.r_addr_msb  = r_addr;
  assign bus.gnt         = gnt;
  assign bus.rd_valid    = rd_valid;
  assign bus.rd_data_lsb = data_lsb;
  assign bus.rd_data_msb = data_msb;
  assign bus.busy        = busy;
  assign bus.window_miss = window_miss;
endmodule

// File: tb/tb_playfield_rd_arbiter.sv
// Directed bench for playfield_rd_arbiter: vector table plus corner sequences,
// with an RD_LAT=2 instance and an RD_LAT=4 instance.
module tb_playfield_rd_arbiter;
  localparam int unsigned NREQ = 4;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  playfield_rd_if #(.NUM_REQ(NREQ)) bus ();
  playfield_rd_if #(.NUM_REQ(NREQ)) bus4 ();

  playfield_rd_arbiter #(.NUM_REQ(NREQ), .RD_LAT(2), .WIN_VSTART(1), .WIN_VEND(30)) dut (
    .clk_65M(clk), .clear(clear), .bus(bus)
  );
  playfield_rd_arbiter #(.NUM_REQ(NREQ), .RD_LAT(4), .WIN_VSTART(1), .WIN_VEND(30)) dut4 (
    .clk_65M(clk), .clear(clear), .bus(bus4)
  );

  // Deterministic row contents per address and plane.
  function automatic logic [0:1023] row(input logic [9:0] a, input logic plane);
    logic [0:1023] r;
    for (int i = 0; i < 32; i++) begin
      r[i*32 +: 32] = (32'(a) * 32'h9E37_79B1) ^ (32'(i) << 8) ^ (plane ? 32'hA5A5_0000 : 32'h0);
    end
    return r;
  endfunction

  // BRAM models: read data appears RD_LAT edges after the address.
  logic [9:0] pl2 [2];
  logic [9:0] pm2 [2];
  logic [9:0] pl4 [4];
  logic [9:0] pm4 [4];
  always @(posedge clk) begin
    pl2[0] <= bus.r_addr_lsb;  pl2[1] <= pl2[0];
    pm2[0] <= bus.r_addr_msb;  pm2[1] <= pm2[0];
    pl4[0] <= bus4.r_addr_lsb; pl4[1] <= pl4[0]; pl4[2] <= pl4[1]; pl4[3] <= pl4[2];
    pm4[0] <= bus4.r_addr_msb; pm4[1] <= pm4[0]; pm4[2] <= pm4[1]; pm4[3] <= pm4[2];
  end
  assign bus.r_data_lsb  = row(pl2[1], 1'b0);
  assign bus.r_data_msb  = row(pm2[1], 1'b1);
  assign bus4.r_data_lsb = row(pl4[3], 1'b0);
  assign bus4.r_data_msb = row(pm4[3], 1'b1);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_row(input string nm, input logic [0:1023] got, input logic [0:1023] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got[0:63]=%h exp[0:63]=%h t=%0t", nm, got[0:63], exp[0:63], $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear = 1'b1;
    bus.req = '0;
    bus4.req = '0;
    step();
    step();
    clear = 1'b0;
  endtask

  function automatic logic [3:0] oh(input int unsigned j);
    return 4'(1) << j;
  endfunction

  function automatic logic [39:0] pk(input logic [9:0] a0, input logic [9:0] a1,
                                     input logic [9:0] a2, input logic [9:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  typedef struct {
    logic [16:0]  v;
    logic [3:0]   req;
    logic [39:0]  addrs;
    logic         grant;
    int unsigned  j;
    logic [9:0]   ea;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // Vector table: expected winner follows the round-robin pointer history.
    vecs[0] = '{17'd5,  4'b0001, pk(10'h12A, 10'h000, 10'h000, 10'h000), 1'b1, 0, 10'h12A};
    vecs[1] = '{17'd10, 4'b1111, pk(10'h001, 10'h3FF, 10'h200, 10'h155), 1'b1, 1, 10'h3FF};
    vecs[2] = '{17'd1,  4'b1011, pk(10'h011, 10'h022, 10'h033, 10'h044), 1'b1, 3, 10'h044};
    vecs[3] = '{17'd30, 4'b0011, pk(10'h0AA, 10'h0BB, 10'h000, 10'h000), 1'b1, 0, 10'h0AA};
    vecs[4] = '{17'd20, 4'b0001, pk(10'h3C3, 10'h000, 10'h000, 10'h000), 1'b1, 0, 10'h3C3};
    vecs[5] = '{17'd15, 4'b0101, pk(10'h100, 10'h200, 10'h2F0, 10'h300), 1'b1, 2, 10'h2F0};
    vecs[6] = '{17'd0,  4'b1111, pk(10'h001, 10'h002, 10'h003, 10'h004), 1'b0, 0, 10'h000};
    vecs[7] = '{17'd31, 4'b1111, pk(10'h001, 10'h002, 10'h003, 10'h004), 1'b0, 0, 10'h000};
    vecs[8] = '{17'd16, 4'b1111, pk(10'h010, 10'h020, 10'h030, 10'h040), 1'b1, 3, 10'h040};
    vecs[9] = '{17'd16, 4'b1110, pk(10'h000, 10'h1F1, 10'h2F2, 10'h3F3), 1'b1, 1, 10'h1F1};

    clear = 1'b1;
    bus.h_count = 17'd100;  bus.v_count = 17'd0;  bus.req = '0;  bus.req_addr = '0;
    bus4.h_count = 17'd5;   bus4.v_count = 17'd0; bus4.req = '0; bus4.req_addr = '0;
    step();
    #2;
    chk("rst_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_addr", 64'(bus.r_addr_lsb), 64'd0);
    chk("rst_wm", 64'(bus.window_miss), 64'd0);
    chk_row("rst_data", bus.rd_data_lsb, '0);
    step();
    clear = 1'b0;

    // Table-driven single transactions.
    for (int i = 0; i < 10; i++) begin
      bus.v_count  = vecs[i].v;
      bus.req      = vecs[i].req;
      bus.req_addr = vecs[i].addrs;
      step();
      if (vecs[i].grant) begin
        chk($sformatf("v%0d_gnt1", i), 64'(bus.gnt), 64'(oh(vecs[i].j)));
        chk($sformatf("v%0d_alsb", i), 64'(bus.r_addr_lsb), 64'(vecs[i].ea));
        chk($sformatf("v%0d_amsb", i), 64'(bus.r_addr_msb), 64'(vecs[i].ea));
        chk($sformatf("v%0d_busy", i), 64'(bus.busy), 64'd1);
        step();
        step();
        chk($sformatf("v%0d_gnt3", i), 64'(bus.gnt), 64'(oh(vecs[i].j)));
        chk($sformatf("v%0d_val3", i), 64'(bus.rd_valid), 64'd0);
        step();
        chk($sformatf("v%0d_val4", i), 64'(bus.rd_valid), 64'(oh(vecs[i].j)));
        chk_row($sformatf("v%0d_dlsb", i), bus.rd_data_lsb, row(vecs[i].ea, 1'b0));
        chk_row($sformatf("v%0d_dmsb", i), bus.rd_data_msb, row(vecs[i].ea, 1'b1));
        bus.req = '0;
        step();
        chk($sformatf("v%0d_val5", i), 64'(bus.rd_valid), 64'd0);
        chk($sformatf("v%0d_idle", i), 64'(bus.busy), 64'd0);
      end else begin
        chk($sformatf("v%0d_nognt", i), 64'(bus.gnt), 64'd0);
        chk($sformatf("v%0d_nobusy", i), 64'(bus.busy), 64'd0);
        step();
        step();
        step();
        chk($sformatf("v%0d_noval", i), 64'(bus.rd_valid), 64'd0);
        chk($sformatf("v%0d_nognt4", i), 64'(bus.gnt), 64'd0);
        bus.req = '0;
        step();
      end
      chk($sformatf("v%0d_wm", i), 64'(bus.window_miss), 64'd0);
    end

    // Continuous 1111: grants 0,1,2,3,0 at 4-cycle spacing.
    do_reset();
    bus.v_count  = 17'd5;
    bus.req_addr = pk(10'h101, 10'h102, 10'h103, 10'h104);
    bus.req      = 4'b1111;
    for (int c = 1; c <= 20; c++) begin
      int unsigned m;
      int unsigned ph;
      step();
      m  = ((c - 1) / 4) % 4;
      ph = (c - 1) % 4;
      if (ph == 0) chk($sformatf("rr_addr_c%0d", c), 64'(bus.r_addr_lsb), 64'(32'h101 + m));
      if (ph < 3) chk($sformatf("rr_gnt_c%0d", c), 64'(bus.gnt), 64'(oh(m)));
      if (ph == 3) begin
        chk($sformatf("rr_val_c%0d", c), 64'(bus.rd_valid), 64'(oh(m)));
        chk_row($sformatf("rr_data_c%0d", c), bus.rd_data_lsb, row(10'(32'h101 + m), 1'b0));
      end else begin
        chk($sformatf("rr_noval_c%0d", c), 64'(bus.rd_valid), 64'd0);
      end
    end
    bus.req = '0;
    step();

    // Window gating and sticky window_miss.
    do_reset();
    bus.h_count  = 17'd10;
    bus.v_count  = 17'd40;
    bus.req_addr = pk(10'h000, 10'h000, 10'h2A2, 10'h000);
    bus.req      = 4'b0100;
    chk("wg_wm0", 64'(bus.window_miss), 64'd0);
    step(); step(); step();
    chk("wg_nognt", 64'(bus.gnt), 64'd0);
    chk("wg_nobusy", 64'(bus.busy), 64'd0);
    bus.v_count = 17'd31; bus.h_count = 17'd0;
    step();
    chk("wg_wm_set", 64'(bus.window_miss), 64'd1);
    chk("wg_nognt31", 64'(bus.gnt), 64'd0);
    bus.h_count = 17'd1;
    step();
    chk("wg_wm_sticky", 64'(bus.window_miss), 64'd1);
    bus.v_count = 17'd40; bus.h_count = 17'd0;
    step();
    chk("wg_wm_hold", 64'(bus.window_miss), 64'd1);
    bus.v_count = 17'd0; bus.h_count = 17'd0;
    step();
    chk("wg_wm_clr", 64'(bus.window_miss), 64'd0);
    chk("wg_nognt_v0", 64'(bus.gnt), 64'd0);
    bus.v_count = 17'd1; bus.h_count = 17'd5;
    step();
    chk("wg_gnt_v1", 64'(bus.gnt), 64'(4'b0100));
    chk("wg_addr_v1", 64'(bus.r_addr_lsb), 64'(10'h2A2));
    step(); step(); step();
    chk("wg_val", 64'(bus.rd_valid), 64'(4'b0100));
    bus.req = '0;
    step();

    // Requester drops req mid-read; the read still completes.
    do_reset();
    bus.v_count  = 17'd5;
    bus.h_count  = 17'd5;
    bus.req_addr = pk(10'h055, 10'h000, 10'h000, 10'h000);
    bus.req      = 4'b0001;
    step();
    chk("drop_gnt", 64'(bus.gnt), 64'(4'b0001));
    step();
    bus.req = '0;
    bus.req_addr = pk(10'h3AA, 10'h000, 10'h000, 10'h000);
    step();
    step();
    chk("drop_val", 64'(bus.rd_valid), 64'(4'b0001));
    chk_row("drop_data", bus.rd_data_lsb, row(10'h055, 1'b0));
    step();
    chk("drop_idle", 64'(bus.busy), 64'd0);
    chk("drop_nognt", 64'(bus.gnt), 64'd0);
    chk("drop_addr_hold", 64'(bus.r_addr_msb), 64'(10'h055));

    // Window closes mid-read; read completes, no new grant, no miss for the granted requester.
    bus.v_count  = 17'd30;
    bus.h_count  = 17'd5;
    bus.req_addr = pk(10'h0AB, 10'h000, 10'h000, 10'h000);
    bus.req      = 4'b0001;
    step();
    chk("wc_gnt", 64'(bus.gnt), 64'(4'b0001));
    step();
    bus.v_count = 17'd31; bus.h_count = 17'd0;
    step();
    bus.h_count = 17'd1;
    step();
    chk("wc_val", 64'(bus.rd_valid), 64'(4'b0001));
    chk_row("wc_data", bus.rd_data_msb, row(10'h0AB, 1'b1));
    chk("wc_wm", 64'(bus.window_miss), 64'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("wc_nognt%0d", c), 64'(bus.gnt | 4'(bus.busy)), 64'd0);
    end
    bus.req = '0;

    // Clear asserted mid-read aborts at once; requester 0 wins afterwards.
    bus.v_count  = 17'd5;
    bus.h_count  = 17'd5;
    bus.req_addr = pk(10'h077, 10'h088, 10'h099, 10'h0EE);
    bus.req      = 4'b0001;
    step();
    chk("rm_gnt", 64'(bus.gnt), 64'(4'b0001));
    step();
    #2;
    clear = 1'b1;
    #1;
    chk("rm_gnt0", 64'(bus.gnt), 64'd0);
    chk("rm_val0", 64'(bus.rd_valid), 64'd0);
    chk("rm_busy0", 64'(bus.busy), 64'd0);
    chk("rm_addr0", 64'(bus.r_addr_lsb), 64'd0);
    chk_row("rm_data0", bus.rd_data_lsb, '0);
    bus.req = 4'b1111;
    step();
    chk("rm_hold_gnt", 64'(bus.gnt), 64'd0);
    step();
    chk("rm_hold_val", 64'(bus.rd_valid), 64'd0);
    #3;
    clear = 1'b0;
    step();
    chk("rm_win0", 64'(bus.gnt), 64'(4'b0001));
    chk("rm_nospur", 64'(bus.rd_valid), 64'd0);
    step(); step();
    chk("rm_nospur3", 64'(bus.rd_valid), 64'd0);
    step();
    chk("rm_val", 64'(bus.rd_valid), 64'(4'b0001));
    chk_row("rm_data", bus.rd_data_lsb, row(10'h077, 1'b0));
    bus.req = '0;
    step();

    // RD_LAT=4 instance: rd_valid at cycle 6, grants spaced 6 cycles.
    bus4.v_count  = 17'd5;
    bus4.req_addr = pk(10'h2C3, 10'h1D4, 10'h000, 10'h000);
    bus4.req      = 4'b0011;
    for (int c = 1; c <= 12; c++) begin
      int unsigned m;
      int unsigned ph;
      step();
      m  = (c - 1) / 6;
      ph = (c - 1) % 6;
      if (ph == 0) chk($sformatf("l4_addr_c%0d", c), 64'(bus4.r_addr_lsb), 64'(m == 0 ? 10'h2C3 : 10'h1D4));
      if (ph < 5) chk($sformatf("l4_gnt_c%0d", c), 64'(bus4.gnt), 64'(oh(m)));
      if (ph == 5) begin
        chk($sformatf("l4_val_c%0d", c), 64'(bus4.rd_valid), 64'(oh(m)));
        chk_row($sformatf("l4_data_c%0d", c), bus4.rd_data_lsb, row(m == 0 ? 10'h2C3 : 10'h1D4, 1'b0));
      end else begin
        chk($sformatf("l4_noval_c%0d", c), 64'(bus4.rd_valid), 64'd0);
      end
    end
    bus4.req = '0;
    step();
    chk("l4_idle", 64'(bus4.busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
